// File: rtl/clock_switch_pkg.sv
// Shared definitions for the clock-switch initiator: one-hot state codes and mux select encodings.
package clock_switch_pkg;

  localparam int unsigned ST_W = 6;

  localparam logic [ST_W-1:0] ST_IDLE   = 6'b000001;
  localparam logic [ST_W-1:0] ST_SELECT = 6'b000010;
  localparam logic [ST_W-1:0] ST_HOLD   = 6'b000100;
  localparam logic [ST_W-1:0] ST_WAIT   = 6'b001000;
  localparam logic [ST_W-1:0] ST_DONE   = 6'b010000;
  localparam logic [ST_W-1:0] ST_FAIL   = 6'b100000;

  localparam logic SEL_CLK1 = 1'b0;
  localparam logic SEL_CLK2 = 1'b1;

  typedef enum logic [ST_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_SELECT = ST_SELECT,
    S_HOLD   = ST_HOLD,
    S_WAIT   = ST_WAIT,
    S_DONE   = ST_DONE,
    S_FAIL   = ST_FAIL
  } state_e;

endpackage

// File: rtl/clock_switch_ctrl_if.sv
// Handshake bundle between a switch requester / PLL / detector and the clock-switch controller.
interface clock_switch_ctrl_if;
  import clock_switch_pkg::*;

  logic            req;
  logic            req_sel;
  logic            c_lock;
  logic            sw_done;
  logic            clk_sel;
  logic            pll_rst;
  logic            busy;
  logic            done;
  logic            fail;
  logic [1:0]      retries;
  logic [ST_W-1:0] state;

  modport master (
    output req, req_sel, c_lock, sw_done,
    input  clk_sel, pll_rst, busy, done, fail, retries, state
  );

  modport slave (
    input  req, req_sel, c_lock, sw_done,
    output clk_sel, pll_rst, busy, done, fail, retries, state
  );

endinterface

// File: rtl/switch_timer.sv
// Shared interval counter: synchronous clear, count enable and terminal-count compare.
module switch_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             hit_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) cnt <= '0;
    else if (en)       cnt <= cnt + CNT_W'(1);
  end

  assign hit_c = en && (cnt == term);

endmodule

// File: rtl/clock_switch_ctrl.sv
// Clock-switch initiator: selects a new reference source, pulses PLL reset, waits for lock
// with bounded retries, and falls back to the default source on repeated timeout.
module clock_switch_ctrl
  import clock_switch_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 12,
  parameter logic        DEFAULT_SEL    = SEL_CLK1
) (
  input logic               clk,
  input logic               reset,
  clock_switch_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic       clk_sel_q, clk_sel_d;
  logic       pll_rst_q, pll_rst_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;
  logic [1:0] retries_q, retries_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_term;
  logic             tmr_hit_c;

  // One timer serves both the reset-hold interval and the lock timeout.
  assign tmr_en   = (state_q == S_HOLD) || (state_q == S_WAIT);
  assign tmr_term = (state_q == S_HOLD) ? CNT_W'(HOLD_CYCLES - 1)
                                        : CNT_W'(TIMEOUT_CYCLES - 1);
  assign tmr_clr  = (state_d != state_q);

  switch_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .hit_c (tmr_hit_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      clk_sel_q <= DEFAULT_SEL;
      pll_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      retries_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      clk_sel_q <= clk_sel_d;
      pll_rst_q <= pll_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      retries_q <= retries_d;
    end
  end

  // Outputs are computed for the state being entered so they register alongside it.
  always_comb begin
    state_d   = state_q;
    clk_sel_d = clk_sel_q;
    pll_rst_d = pll_rst_q;
    done_d    = 1'b0;
    fail_d    = fail_q;
    retries_d = retries_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          fail_d = 1'b0;
          if (bus.req_sel != clk_sel_q) begin
            retries_d = 2'd0;
            clk_sel_d = bus.req_sel;
            pll_rst_d = 1'b1;
            state_d   = S_SELECT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SELECT: state_d = S_HOLD;
      S_HOLD: begin
        if (tmr_hit_c) begin
          pll_rst_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Lock wins over a coincident timeout.
        if (bus.c_lock && bus.sw_done) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (tmr_hit_c) begin
          if (retries_q < 2'(MAX_RETRY)) begin
            retries_d = retries_q + 2'd1;
            pll_rst_d = 1'b1;
            state_d   = S_SELECT;
          end else begin
            clk_sel_d = DEFAULT_SEL;
            pll_rst_d = 1'b0;
            fail_d    = 1'b1;
            state_d   = S_FAIL;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: begin
        clk_sel_d = DEFAULT_SEL;
        pll_rst_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.state   = state_q;
  assign bus.clk_sel = clk_sel_q;
  assign bus.pll_rst = pll_rst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fail    = fail_q;
  assign bus.retries = retries_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Bench for clock_switch_ctrl: directed scenarios with literal expectations, then random traffic,
// every cycle compared against an attempt-offset model of the switch sequence.
module tb_clock_switch_ctrl;
  import clock_switch_pkg::*;

  localparam int   H    = 4;
  localparam int   T    = 16;
  localparam int   MR   = 2;
  localparam int   CW   = 5;
  localparam logic DSEL = SEL_CLK1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  clock_switch_ctrl_if bus();

  clock_switch_ctrl #(
    .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR), .CNT_W(CW), .DEFAULT_SEL(DSEL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: mode 0 idle, 1 in an attempt, 2 done cycle, 3 fail cycle; m_d = cycles since attempt start.
  int   m_mode = 0;
  int   m_d    = 0;
  int   m_att  = 0;
  logic m_sel  = DSEL;
  logic m_fail = 1'b0;
  logic m_noop = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_state();
    if (m_mode == 0) return 1;
    if (m_mode == 2) return 16;
    if (m_mode == 3) return 32;
    if (m_d == 0)    return 2;
    if (m_d <= H)    return 4;
    return 8;
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_mode = 0; m_d = 0; m_att = 0; m_sel = DSEL; m_fail = 1'b0; m_noop = 1'b0;
    end else begin
      m_noop = 1'b0;
      if (m_mode == 0) begin
        if (bus.req) begin
          m_fail = 1'b0;
          if (bus.req_sel != m_sel) begin
            m_mode = 1; m_d = 0; m_att = 0; m_sel = bus.req_sel;
          end else begin
            m_noop = 1'b1;
          end
        end
      end else if (m_mode == 1) begin
        if (m_d <= H) m_d++;
        else if (bus.c_lock && bus.sw_done) m_mode = 2;
        else if (m_d - H - 1 == T - 1) begin
          if (m_att < MR) begin
            m_att++; m_d = 0;
          end else begin
            m_mode = 3; m_sel = DSEL; m_fail = 1'b1;
          end
        end else m_d++;
      end else begin
        m_mode = 0;
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare every output just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("state",   int'(bus.state),   exp_state());
    chk("clk_sel", int'(bus.clk_sel), int'(m_sel));
    chk("pll_rst", int'(bus.pll_rst), int'(m_mode == 1 && m_d <= H));
    chk("busy",    int'(bus.busy),    int'(m_mode != 0));
    chk("done",    int'(bus.done),    int'(m_mode == 2 || m_noop));
    chk("fail",    int'(bus.fail),    int'(m_fail));
    chk("retries", int'(bus.retries), m_att);
  endtask

  task automatic quiet();
    bus.req = 1'b0; bus.req_sel = 1'b0; bus.c_lock = 1'b0; bus.sw_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; step(); step(); reset = 1'b1;
  endtask

  task automatic request(input logic sel);
    bus.req = 1'b1; bus.req_sel = sel; step(); bus.req = 1'b0;
  endtask

  initial begin
    int pll_cnt, pulses, done_at, n_done, max_r, fail_at, lock_mode;
    logic prev, got;

    quiet();
    // Scenario 1: reset state, then a clean switch to clk2 with lock after five WAIT cycles.
    do_reset();
    step();
    chk("rst_state", int'(bus.state), 1);
    chk("rst_sel", int'(bus.clk_sel), 0);
    chk("rst_pll", int'(bus.pll_rst), 0);
    chk("rst_retries", int'(bus.retries), 0);
    request(SEL_CLK2);
    chk("s1_sel", int'(bus.clk_sel), 1);
    pll_cnt = bus.pll_rst ? 1 : 0; done_at = -1; n_done = 0;
    for (int j = 1; j <= 30; j++) begin
      bus.c_lock = (j == 11); bus.sw_done = (j == 11);
      step();
      if (bus.pll_rst) pll_cnt++;
      if (bus.done) begin n_done++; if (done_at < 0) done_at = j; end
      if (j == 12) chk("s1_busy_after", int'(bus.busy), 0);
    end
    quiet();
    chk("s1_pll_len", pll_cnt, 5);
    chk("s1_done_at", done_at, 11);
    chk("s1_done_n", n_done, 1);
    chk("s1_retries", int'(bus.retries), 0);

    // Scenario 2: no-op request to the current source.
    request(SEL_CLK2);
    chk("s2_done", int'(bus.done), 1);
    chk("s2_busy", int'(bus.busy), 0);
    chk("s2_pll", int'(bus.pll_rst), 0);
    step();
    chk("s2_done_once", int'(bus.done), 0);

    // Scenario 3: lock never arrives; three attempts then fallback.
    do_reset();
    request(SEL_CLK2);
    pll_cnt = bus.pll_rst ? 1 : 0; pulses = pll_cnt; prev = bus.pll_rst;
    max_r = 0; got = 1'b0; fail_at = -1;
    for (int j = 1; j <= 200 && !got; j++) begin
      step();
      if (bus.pll_rst) begin pll_cnt++; if (!prev) pulses++; end
      prev = bus.pll_rst;
      if (int'(bus.retries) > max_r) max_r = int'(bus.retries);
      if (bus.state == ST_FAIL) begin got = 1'b1; fail_at = j; end
    end
    chk("s3_fail_reached", int'(got), 1);
    chk("s3_fail_at", fail_at, 63);
    chk("s3_pulses", pulses, 3);
    chk("s3_pll_total", pll_cnt, 15);
    chk("s3_max_retries", max_r, 2);
    chk("s3_sel_default", int'(bus.clk_sel), 0);
    chk("s3_fail", int'(bus.fail), 1);
    repeat (3) step();
    chk("s3_fail_sticky", int'(bus.fail), 1);
    request(SEL_CLK2);
    chk("s3_fail_clear", int'(bus.fail), 0);

    // Scenario 4: lock present, detector done only on the second attempt.
    bus.c_lock = 1'b1; n_done = 0; got = 1'b0;
    for (int j = 0; j < 100 && !got; j++) begin
      bus.sw_done = (m_att >= 1);
      step();
      if (bus.done) n_done++;
      if (!bus.busy) got = 1'b1;
    end
    quiet();
    chk("s4_finished", int'(got), 1);
    chk("s4_done_n", n_done, 1);
    chk("s4_retries", int'(bus.retries), 1);
    chk("s4_fail", int'(bus.fail), 0);
    chk("s4_sel", int'(bus.clk_sel), 1);

    // Scenario 5: reset in HOLD aborts; a request while busy is dropped.
    do_reset();
    request(SEL_CLK2);
    step(); step();
    reset = 1'b0; step(); reset = 1'b1;
    chk("s5_state", int'(bus.state), 1);
    chk("s5_pll", int'(bus.pll_rst), 0);
    chk("s5_sel", int'(bus.clk_sel), 0);
    chk("s5_done", int'(bus.done), 0);
    chk("s5_fail", int'(bus.fail), 0);
    request(SEL_CLK2);
    repeat (7) step();
    request(SEL_CLK1);
    bus.c_lock = 1'b1; bus.sw_done = 1'b1; step(); quiet();
    repeat (5) step();
    chk("s5_no_queue_busy", int'(bus.busy), 0);
    chk("s5_no_queue_sel", int'(bus.clk_sel), 1);

    // Scenario 6: lock on the very last timeout cycle wins.
    request(SEL_CLK1);
    repeat (20) step();
    bus.c_lock = 1'b1; bus.sw_done = 1'b1; step(); quiet();
    chk("s6_state_done", int'(bus.state), 16);
    chk("s6_retries", int'(bus.retries), 0);
    chk("s6_done", int'(bus.done), 1);
    step();
    chk("s6_sel", int'(bus.clk_sel), 0);

    // Random traffic with a lock probability that varies per window.
    lock_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) lock_mode = int'($urandom_range(0, 2));
      bus.req     = ($urandom_range(0, 5) == 0);
      bus.req_sel = 1'($urandom_range(0, 1));
      bus.c_lock  = (lock_mode == 0) ? ($urandom_range(0, 2) == 0) :
                    (lock_mode == 1) ? ($urandom_range(0, 11) == 0) : 1'b1;
      bus.sw_done = (lock_mode == 2) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      reset       = !($urandom_range(0, 399) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
